// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, redirect request and decode dequeue port.
// The queue side uses the master modport; the fetch/decode environment uses slave.
interface fetch_queue_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ack_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_ir;
    logic        deq_misaligned;

    modport master (
        output imem_addr, imem_req, deq_valid, deq_pc, deq_ir, deq_misaligned,
        input  imem_data, imem_ack_n, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_addr, imem_req, deq_valid, deq_pc, deq_ir, deq_misaligned,
        output imem_data, imem_ack_n, redirect, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, ir, misaligned} fed from imem, drained by decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming word to decode the same cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_queue_if.master              bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_IR   = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;

    logic [31:0] pc_mem_q  [DEPTH];
    logic [31:0] ir_mem_q  [DEPTH];
    logic        mis_mem_q [DEPTH];

    logic             full, empty, imem_req, push, pop_st, store, bypass_vld;
    logic             wr_en, wr_mis;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_pc, wr_ir;

    always_comb begin
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        // A stored pop frees the slot this cycle, so a full queue may still fetch.
        imem_req = rst_n & ~halted_q & ~bus.redirect & (~full | (bus.deq_ready & ~empty));
        push     = imem_req & ~bus.imem_ack_n;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_vld = empty & push;
`else
        bypass_vld = 1'b0;
`endif
        pop_st = ~bus.redirect & ~empty & bus.deq_ready;
        store  = push & ~(bypass_vld & bus.deq_ready);
    end

    always_comb begin
        bus.imem_addr = fetch_pc_q;
        bus.imem_req  = imem_req;
        bus.deq_valid = rst_n & (~empty | bypass_vld);
        if (bypass_vld) begin
            bus.deq_pc         = fetch_pc_q;
            bus.deq_ir         = bus.imem_data;
            bus.deq_misaligned = 1'b0;
        end else begin
            bus.deq_pc         = pc_mem_q[rd_ptr_q];
            bus.deq_ir         = ir_mem_q[rd_ptr_q];
            bus.deq_misaligned = rst_n & ~empty & mis_mem_q[rd_ptr_q];
        end
        count = count_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        halted_d   = halted_q;
        wr_en      = 1'b0;
        wr_idx     = wr_ptr_q;
        wr_pc      = fetch_pc_q;
        wr_ir      = bus.imem_data;
        wr_mis     = 1'b0;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            halted_d   = 1'b0;
            // Misaligned target: leave a single marker entry and stop fetching.
            if (bus.redirect_pc[1:0] != 2'b00) begin
                halted_d = 1'b1;
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_pc    = bus.redirect_pc;
                wr_ir    = NOP_IR;
                wr_mis   = 1'b1;
                wr_ptr_d = PTR_W'(1);
                count_d  = CNT_W'(1);
            end
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + 32'd4;
            if (store) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_st) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(store) - CNT_W'(pop_st);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_idx]  <= wr_pc;
            ir_mem_q[wr_idx]  <= wr_ir;
            mis_mem_q[wr_idx] <= wr_mis;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       data_fixed;
    logic [31:0] fixed_word;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .count (count)
    );

    assign bus.imem_data = data_fixed ? fixed_word : (bus.imem_addr ^ 32'hDEAD_BEEF);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch;
    bit          m_halted;
    bit          m_init = 1'b0;

    always @(negedge clk) begin : cmp
        int   n;
        bit   e_req, byp, e_valid, pop, push;
        ent_t e;
        n       = mq.size();
        e_req   = !m_halted && !bus.redirect && (n < DEPTH || (bus.deq_ready && n > 0));
        byp     = BYP && n == 0 && e_req && !bus.imem_ack_n;
        e_valid = (n > 0) || byp;
        if (!rst_n) begin
            check("rst_imem_req", 32'(bus.imem_req), 32'd0);
            check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
            check("rst_deq_mis", 32'(bus.deq_misaligned), 32'd0);
            mq.delete();
            m_fetch  = RESET_PC;
            m_halted = 1'b0;
            m_init   = 1'b1;
        end else if (m_init) begin
            check("m_imem_addr", bus.imem_addr, m_fetch);
            check("m_imem_req", 32'(bus.imem_req), 32'(e_req));
            check("m_deq_valid", 32'(bus.deq_valid), 32'(e_valid));
            check("m_count", 32'(count), 32'(n));
            if (e_valid) begin
                if (byp) e = '{pc: m_fetch, ir: bus.imem_data, mis: 1'b0};
                else     e = mq[0];
                check("m_deq_pc", bus.deq_pc, e.pc);
                check("m_deq_ir", bus.deq_ir, e.ir);
                check("m_deq_mis", 32'(bus.deq_misaligned), 32'(e.mis));
            end
            if (bus.redirect) begin
                mq.delete();
                m_fetch  = bus.redirect_pc;
                m_halted = (bus.redirect_pc[1:0] != 2'b00);
                if (m_halted) mq.push_back('{pc: bus.redirect_pc, ir: 32'h0000_0013, mis: 1'b1});
            end else begin
                pop  = (n > 0) && bus.deq_ready;
                push = e_req && !bus.imem_ack_n;
                if (pop) void'(mq.pop_front());
                if (push && !(byp && bus.deq_ready))
                    mq.push_back('{pc: m_fetch, ir: bus.imem_data, mis: 1'b0});
                if (push) m_fetch = m_fetch + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.imem_ack_n  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.deq_ready   = 1'b0;
        data_fixed      = 1'b0;
        fixed_word      = 32'h0;
        repeat (3) tick();
        #1;
        check("reset_req", 32'(bus.imem_req), 32'd0);
        check("reset_valid", 32'(bus.deq_valid), 32'd0);

        // Fill from reset with decode stalled.
        rst_n = 1'b1;
        bus.imem_ack_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_addr", bus.imem_addr, 32'(4 * i));
            check("fill_req", 32'(bus.imem_req), 32'd1);
            tick();
        end
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_req", 32'(bus.imem_req), 32'd0);
        check("full_head_pc", bus.deq_pc, 32'h0);
        check("full_head_ir", bus.deq_ir, 32'hDEAD_BEEF);

        // Pop and push together while full.
        bus.deq_ready = 1'b1;
        #1;
        check("full_pop_req", 32'(bus.imem_req), 32'd1);
        tick();
        bus.deq_ready = 1'b0;
        #1;
        check("pp_count", 32'(count), 32'd4);
        check("pp_head_pc", bus.deq_pc, 32'h4);
        check("pp_addr", bus.imem_addr, 32'd20);

        // Stalled head holds, then drain one without fetching.
        bus.imem_ack_n = 1'b1;
        tick();
        tick();
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        #1;
        check("drain_count", 32'(count), 32'd3);

        // Redirect with ack active and a pop attempt: both ignored.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.imem_ack_n = 1'b0;
        bus.deq_ready = 1'b1;
        #1;
        check("redir_req", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect = 1'b0;
        bus.deq_ready = 1'b0;
        bus.imem_ack_n = 1'b1;
        #1;
        check("redir_count", 32'(count), 32'd0);
        check("redir_addr", bus.imem_addr, 32'h100);
        check("redir_valid", 32'(bus.deq_valid), 32'd0);

        // Not-ready memory holds the address.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_addr", bus.imem_addr, 32'h40);
            check("stall_count", 32'(count), 32'd0);
            tick();
        end
        bus.imem_ack_n = 1'b0;
        tick();
        bus.imem_ack_n = 1'b1;
        #1;
        check("ack_count", 32'(count), 32'd1);
        check("ack_head_pc", bus.deq_pc, 32'h40);
        check("ack_addr", bus.imem_addr, 32'h44);

        // Misaligned redirect leaves a marker and halts fetching.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h102;
        tick();
        bus.redirect = 1'b0;
        bus.imem_ack_n = 1'b0;
        #1;
        check("mis_valid", 32'(bus.deq_valid), 32'd1);
        check("mis_flag", 32'(bus.deq_misaligned), 32'd1);
        check("mis_pc", bus.deq_pc, 32'h102);
        check("mis_ir", bus.deq_ir, 32'h0000_0013);
        check("mis_req", 32'(bus.imem_req), 32'd0);
        repeat (2) tick();
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        #1;
        check("halt_req", 32'(bus.imem_req), 32'd0);
        check("halt_count", 32'(count), 32'd0);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        bus.imem_ack_n = 1'b1;
        #1;
        check("resume_req", 32'(bus.imem_req), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h200);

        // Empty queue, word arrives with decode ready.
        data_fixed = 1'b1;
        fixed_word = 32'h0050_0093;
        bus.imem_ack_n = 1'b0;
        bus.deq_ready = 1'b1;
        #1;
        check("byp_valid", 32'(bus.deq_valid), 32'(BYP));
        if (BYP) check("byp_ir", bus.deq_ir, 32'h0050_0093);
        tick();
        bus.imem_ack_n = 1'b1;
        #1;
        check("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);
        check("byp_next_valid", 32'(bus.deq_valid), BYP ? 32'd0 : 32'd1);
        if (!BYP) check("nb_ir", bus.deq_ir, 32'h0050_0093);
        tick();
        bus.deq_ready = 1'b0;
        data_fixed = 1'b0;

        // Address wraps modulo 2^32.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        bus.imem_ack_n = 1'b0;
        bus.deq_ready = 1'b1;
        repeat (2) tick();
        #1;
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Mixed traffic exercising pointer wrap, partial fills and a mid-run redirect.
        for (int i = 0; i < 60; i++) begin
            bus.imem_ack_n  = (i % 3 == 2);
            bus.deq_ready   = (i % 5 == 1) || (i % 5 == 3) || (i > 40 && i % 2 == 0);
            bus.redirect    = (i == 30);
            bus.redirect_pc = 32'h1000;
            tick();
        end
        bus.redirect = 1'b0;

        // Reset mid-operation discards entries and a pending redirect.
        rst_n = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        tick();
        rst_n = 1'b1;
        bus.redirect = 1'b0;
        bus.imem_ack_n = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        check("rst2_addr", bus.imem_addr, RESET_PC);
        check("rst2_req", 32'(bus.imem_req), 32'd1);
        check("rst2_count", 32'(count), 32'd0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port imem_addr  output  32  instruction fetch address (fetch_pc).
REQ-006 Port imem_req  output  1  fetch request this cycle.
REQ-007 Port imem_data  input  32  instruction word, valid when imem_ack_n=0.
REQ-008 Port imem_ack_n  input  1  0 = imem_data valid this cycle; 1 = not ready.
REQ-009 Port redirect  input  1  flush queue and refetch (jump or trap).
REQ-010 Port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 Port deq_valid  output  1  head entry available.
REQ-012 Port deq_ready  input  1  decode consumes head.
REQ-013 Port deq_pc, deq_ir  output  32 each  head entry PC and instruction.
REQ-014 Port deq_misaligned  output  1  head is an instruction-address-misaligned marker.
REQ-015 Port count  output  $clog2(DEPTH+1)  stored entries.

Function
REQ-016 Circular buffer: entries {pc, ir, misaligned}; read/write pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-017 pop = deq_valid & deq_ready; imem_req = rst_n & !halted & !redirect & (!full | pop).
REQ-018 push = imem_req & !imem_ack_n; pushes {fetch_pc, imem_data, 0}; fetch_pc advances by 4, wrapping modulo 2^32.
REQ-019 imem_ack_n=1 with imem_req=1: no push; fetch_pc and imem_addr held.
REQ-020 Push and pop in the same cycle: count unchanged; legal when full.
REQ-021 redirect=1: all entries discarded, count=0 next cycle; that cycle's imem response and any pop are ignored; fetch_pc <= redirect_pc.
REQ-022 redirect_pc[1:0]!=0: next cycle holds one entry {redirect_pc, 32'h0000_0013, 1}; halted=1; no fetches until next redirect.
REQ-023 A later redirect with an aligned PC clears halted and resumes fetching next cycle.
REQ-024 deq_* outputs come combinationally from the head entry; deq_valid=0 when empty (bypass per REQ-029).
REQ-025 deq_pc/deq_ir/deq_misaligned hold stable while deq_valid=1 and deq_ready=0.

Reset
REQ-026 rst_n=0 at a clock edge: fetch_pc=RESET_PC, pointers=0, count=0, halted=0.
REQ-027 While rst_n=0: imem_req=0, deq_valid=0, deq_misaligned=0; storage contents don't-care.
REQ-028 Reset mid-operation: in-flight entries and pending redirect discarded; first request after release uses imem_addr=RESET_PC.

Configuration
REQ-029 FETCH_QUEUE_BYPASS_EN defined: when empty, push and no redirect, deq_valid=1 with deq_pc=fetch_pc, deq_ir=imem_data the same cycle; if deq_ready=1 the word is not stored.
REQ-030 FETCH_QUEUE_BYPASS_EN undefined: words are always stored first; minimum fetch-to-deq latency is 1 cycle.

Verification
REQ-031 Reset, RESET_PC=0, imem_ack_n=0, deq_ready=0 -> imem_addr 0,4,8,12; count reaches 4; imem_req=0; head deq_pc=0.
REQ-032 Full queue, deq_ready=1 for one cycle with ack -> pop pc 0, push pc 16; count stays 4.
REQ-033 redirect=1, redirect_pc=32'h100, with queue at count 3 and ack active -> next cycle count=0, imem_addr=32'h100; response in the redirect cycle not stored.
REQ-034 redirect_pc=32'h102 -> next cycle deq_valid=1, deq_misaligned=1, deq_pc=32'h102; imem_req stays 0 until redirect to 32'h200.
REQ-035 imem_ack_n=1 for 3 cycles at imem_addr=32'h40 -> addr held at 32'h40, count unchanged; on ack, push pc 32'h40.
REQ-036 Bypass build, empty, ack with imem_data=32'h00500093, deq_ready=1 -> same-cycle deq_valid=1, deq_ir=32'h00500093, count stays 0; non-bypass build -> deq_valid next cycle.
